// File: rtl/typing_char_seq.sv
// Round sequencer for the typing tutor: drives the character-mux select, checks typed keys
// against the selected character, counts errors and skips a position after an idle timeout.
module typing_char_seq #(
    parameter int KEY_W       = 8,
    parameter int ERR_W       = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic [KEY_W-1:0] expected,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             miss,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // With the timeout disabled the idle timer is parked at zero and never compared.
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [15:0] TIMER_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYC - 1) : 16'd0;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]  state;
    logic [15:0] timer;
    logic        key_match;
    logic        idle_expired;

    assign key_match    = key_valid && (key_code == expected);
    assign idle_expired = TIMEOUT_EN && (timer == TIMER_LAST);

    // A hit and a timeout both move to the next position; after D the round completes
    // instead of wrapping, so sel only returns to A together with the move to DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= 16'd0;
            sel       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        sel       <= 2'b00;
                        err_count <= '0;
                        timer     <= 16'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        sel       <= 2'b00;
                        err_count <= '0;
                        timer     <= 16'd0;
                    end else if (key_match || (!key_valid && idle_expired)) begin
                        hit     <= key_match;
                        timeout <= !key_match;
                        timer   <= 16'd0;
                        if (!key_match && err_count != ERR_MAX)
                            err_count <= err_count + ERR_W'(1);
                        if (sel == 2'b11) begin
                            sel   <= 2'b00;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            sel <= sel + 2'd1;
                        end
                    end else if (key_valid) begin
                        miss  <= 1'b1;
                        timer <= 16'd0;
                        if (err_count != ERR_MAX)
                            err_count <= err_count + ERR_W'(1);
                    end else if (TIMEOUT_EN) begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_typing_char_seq.sv
// Bench for typing_char_seq: two instances (timeout 8 / 4-bit errors, timeout off / 2-bit
// errors) run in lockstep against a reference model through an expected-result queue.
module tb_typing_char_seq;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] MUX_TABLE [4] = '{8'h63, 8'h61, 8'h74, 8'h73};

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  sel;
        logic [15:0] timer;
        logic [7:0]  err;
        logic        busy;
        logic        done;
        logic        hit;
        logic        miss;
        logic        tmo;
    } model_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       key_valid;
    logic [7:0] key_code;

    logic [7:0] expected0, expected1;
    logic [1:0] sel0, sel1;
    logic       busy0, busy1, done0, done1, hit0, hit1, miss0, miss1, tmo0, tmo1;
    logic [3:0] err0;
    logic [1:0] err1;

    int checks = 0;
    int errors = 0;
    int hit0_cnt, miss1_cnt, tmo0_cnt, tmo1_cnt;

    model_t m0, m1;
    model_t q0[$];
    model_t q1[$];

    always #5 clock = ~clock;

    assign expected0 = MUX_TABLE[sel0];
    assign expected1 = MUX_TABLE[sel1];

    typing_char_seq #(.KEY_W(8), .ERR_W(4), .TIMEOUT_CYC(8)) dut0 (
        .clock(clock), .reset(reset), .start(start), .key_valid(key_valid),
        .key_code(key_code), .expected(expected0), .sel(sel0), .busy(busy0),
        .done(done0), .hit(hit0), .miss(miss0), .timeout(tmo0), .err_count(err0)
    );

    typing_char_seq #(.KEY_W(8), .ERR_W(2), .TIMEOUT_CYC(0)) dut1 (
        .clock(clock), .reset(reset), .start(start), .key_valid(key_valid),
        .key_code(key_code), .expected(expected1), .sel(sel1), .busy(busy1),
        .done(done1), .hit(hit1), .miss(miss1), .timeout(tmo1), .err_count(err1)
    );

    function automatic model_t modelStep(model_t m, logic rst_n, logic st, logic kv,
                                         logic [7:0] kc, int tcyc, int err_max);
        model_t n = m;
        logic   adv = 1'b0;
        n.hit = 1'b0;
        n.miss = 1'b0;
        n.tmo = 1'b0;
        if (!rst_n) return '0;
        if (m.st != S_RUN) begin
            if (st) begin
                n.st = S_RUN; n.sel = 2'd0; n.err = 8'd0; n.timer = 16'd0;
                n.busy = 1'b1; n.done = 1'b0;
            end
        end else if (st) begin
            n.sel = 2'd0; n.err = 8'd0; n.timer = 16'd0;
        end else if (kv && kc == MUX_TABLE[m.sel]) begin
            n.hit = 1'b1; n.timer = 16'd0; adv = 1'b1;
        end else if (kv) begin
            n.miss = 1'b1; n.timer = 16'd0;
            if (int'(m.err) < err_max) n.err = m.err + 8'd1;
        end else if (tcyc != 0 && int'(m.timer) == tcyc - 1) begin
            n.tmo = 1'b1; n.timer = 16'd0; adv = 1'b1;
            if (int'(m.err) < err_max) n.err = m.err + 8'd1;
        end else if (tcyc != 0) begin
            n.timer = m.timer + 16'd1;
        end
        if (adv) begin
            if (m.sel == 2'd3) begin
                n.sel = 2'd0; n.st = S_DONE; n.busy = 1'b0; n.done = 1'b1;
            end else begin
                n.sel = m.sel + 2'd1;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] required);
        checks++;
        if (observed !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, required, $time);
        end
    endtask

    // Pops the expectation queued for this edge and compares it with what each DUT shows.
    task automatic compareOutputs();
        model_t e0, e1;
        checkOutput("queue_ready", 32'(q0.size() != 0 && q1.size() != 0), 32'd1);
        if (q0.size() == 0 || q1.size() == 0) return;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        checkOutput("d0_sel", 32'(sel0), 32'(e0.sel));
        checkOutput("d0_flags", {27'd0, busy0, done0, hit0, miss0, tmo0},
                    {27'd0, e0.busy, e0.done, e0.hit, e0.miss, e0.tmo});
        checkOutput("d0_err", 32'(err0), 32'(e0.err));
        checkOutput("d1_sel", 32'(sel1), 32'(e1.sel));
        checkOutput("d1_flags", {27'd0, busy1, done1, hit1, miss1, tmo1},
                    {27'd0, e1.busy, e1.done, e1.hit, e1.miss, e1.tmo});
        checkOutput("d1_err", 32'(err1), 32'(e1.err));
        hit0_cnt  += int'(hit0);
        miss1_cnt += int'(miss1);
        tmo0_cnt  += int'(tmo0);
        tmo1_cnt  += int'(tmo1);
    endtask

    task automatic applyStimulus(input logic rst_n, input logic st, input logic kv,
                                 input logic [7:0] kc);
        reset = rst_n;
        start = st;
        key_valid = kv;
        key_code = kc;
        m0 = modelStep(m0, rst_n, st, kv, kc, 8, 15);
        m1 = modelStep(m1, rst_n, st, kv, kc, 0, 3);
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge clock);
        #1;
        compareOutputs();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clearCounts();
        hit0_cnt = 0; miss1_cnt = 0; tmo0_cnt = 0; tmo1_cnt = 0;
    endtask

    initial begin
        m0 = '0;
        m1 = '0;
        clearCounts();

        // Reset dominates start and key_valid.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h63);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h63);
        checkOutput("rst_busy", 32'(busy0), 32'd0);
        idleCycles(20);
        checkOutput("idle_sel", 32'(sel0), 32'd0);

        // Perfect round, then a key in DONE.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("run_busy", 32'(busy0), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h63);
        checkOutput("sel_after_a", 32'(sel0), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h61);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h74);
        checkOutput("sel_after_c", 32'(sel0), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h73);
        checkOutput("round_done", {30'd0, done0, busy0}, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h63);
        checkOutput("done_hits", 32'(hit0_cnt), 32'd4);
        checkOutput("done_err", 32'(err0), 32'd0);

        // Mismatch keeps position and counts an error.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h63);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h62);
        checkOutput("miss_sel", 32'(sel0), 32'd1);
        checkOutput("miss_err", 32'(err0), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h61);
        checkOutput("recover_sel", 32'(sel0), 32'd2);

        // Idle timeouts skip positions; the disabled-timeout instance stays put.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        idleCycles(8);
        checkOutput("tmo_pulse", 32'(tmo0), 32'd1);
        checkOutput("tmo_sel", 32'(sel0), 32'd1);
        idleCycles(24);
        checkOutput("tmo_done", 32'(done0), 32'd1);
        checkOutput("tmo_err", 32'(err0), 32'd4);
        idleCycles(68);
        checkOutput("tmo_count", 32'(tmo0_cnt), 32'd4);
        checkOutput("notmo_count", 32'(tmo1_cnt), 32'd0);
        checkOutput("notmo_sel", 32'(sel1), 32'd0);

        // Error counter saturation on the 2-bit instance.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("sat_misses", 32'(miss1_cnt), 32'd5);
        checkOutput("sat_err", 32'(err1), 32'd3);
        checkOutput("wide_err", 32'(err0), 32'd5);

        // Restart collides with a correct key at position C.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h63);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h61);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h74);
        checkOutput("restart_state", {28'd0, sel0, busy0, hit0}, 32'd2);

        // Mid-round reset at position C.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h63);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h61);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h74);
        checkOutput("midrst_busy", 32'(busy0), 32'd0);
        idleCycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
